lfsr_arbiter: RTL and testbench

Round-robin scheduler that shares one internal Fibonacci LFSR between R requesters. Each granted requester receives a fresh N-bit pseudo-random word produced by stepping the LFSR STEPS times, so no two requesters ever see overlapping state. The block sits between the pseudo-random source and its consumers and owns seeding, sequencing and arbitration of the generator.

---
 rtl/lfsr_arbiter.sv | 111 +++++++++++
 tb/tb_lfsr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter sharing one Fibonacci LFSR between R requesters.
// Each grant steps the LFSR STEPS times and delivers the post-shift word.
module lfsr_arbiter #(
    parameter int           N        = 3,
    parameter int           R        = 4,
    parameter int           STEPS    = 3,
    parameter logic [N-1:0] TAPS     = 3'b110,
    parameter logic [N-1:0] SEED_RST = 3'b001
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [R-1:0] req_i,
    output logic [R-1:0] gnt_o,
    output logic         valid_o,
    output logic [N-1:0] data_o,
    input  logic         seed_we_i,
    input  logic [N-1:0] seed_i,
    output logic         busy_o
);

    localparam int LW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, STEP, DELIVER} state_t;

    state_t         state_q;
    logic [N-1:0]   lfsr_q;
    logic [N-1:0]   lfsr_d;
    logic [N-1:0]   seed_d;
    logic [R-1:0]   gnt_q;
    logic [R-1:0]   gnt_d;
    logic           valid_q;
    logic [N-1:0]   data_q;
    logic           busy_q;
    logic [LW-1:0]  last_q;
    logic [LW-1:0]  idx_q;
    logic [LW-1:0]  win_idx_d;
    logic           win_found_d;
    logic [CW-1:0]  cnt_q;

    assign lfsr_d = {lfsr_q[N-2:0], ^(lfsr_q & TAPS)};
    // A zero seed would lock the LFSR, so it is promoted to 1.
    assign seed_d = (seed_i == '0) ? {{(N-1){1'b0}}, 1'b1} : seed_i;

    // Scan last+1 .. last+R (mod R); first asserted request wins.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        for (int k = 1; k <= R; k++) begin
            int j;
            j = (int'(last_q) + k) % R;
            if (!win_found_d && req_i[j]) begin
                win_found_d = 1'b1;
                win_idx_d   = LW'(j);
            end
        end
    end

    assign gnt_d = {{(R-1){1'b0}}, 1'b1} << win_idx_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_RST;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            last_q  <= LW'(R - 1);
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seed_we_i) begin
                        lfsr_q <= seed_d;
                    end else if (win_found_d) begin
                        gnt_q   <= gnt_d;
                        idx_q   <= win_idx_d;
                        cnt_q   <= CW'(STEPS);
                        busy_q  <= 1'b1;
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    lfsr_q <= lfsr_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        valid_q <= 1'b1;
                        data_q  <= lfsr_d;
                        state_q <= DELIVER;
                    end
                end
                DELIVER: begin
                    valid_q <= 1'b0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    last_q  <= idx_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Scoreboard bench for lfsr_arbiter: directed transactions push expected
// {gnt,data}; a negedge monitor pops and compares on every valid strobe.
module tb_lfsr_arbiter;
    localparam int N = 3, R = 4, STEPS = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [R-1:0] req = '0;
    logic         seed_we = 1'b0;
    logic [N-1:0] seed = '0;
    logic [R-1:0] gnt;
    logic         valid;
    logic [N-1:0] data;
    logic         busy;

    lfsr_arbiter #(.N(N), .R(R), .STEPS(STEPS), .TAPS(3'b110), .SEED_RST(3'b001)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .valid_o(valid),
        .data_o(data), .seed_we_i(seed_we), .seed_i(seed), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [R-1:0] g; logic [N-1:0] d; } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, vcount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [R-1:0] g, input logic [N-1:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        q.push_back(e);
    endtask

    // Monitor: protocol invariants every cycle, scoreboard pop on valid.
    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
            check("idle_quiet", 32'(!busy && (gnt != '0 || valid)), 0);
            if (valid) begin
                vcount++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got gnt=%b data=%b expected no strobe", gnt, data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("valid_gnt", 32'(gnt), 32'(e.g));
                    check("valid_data", 32'(data), 32'(e.d));
                end
            end
        end
    end

    // One transaction: req m raised at a negedge, dropped after drop_after
    // busy cycles; optionally pulses seed_we in the second STEP cycle.
    task automatic txn(input logic [R-1:0] m, input logic [R-1:0] eg, input logic [N-1:0] ed,
                       input int drop_after, input logic seed_in_step);
        int cyc, v0;
        push(eg, ed);
        v0 = vcount;
        @(negedge clk);
        req = m;
        @(negedge clk);
        check("busy_rise", 32'(busy), 1);
        check("gnt_first", 32'(gnt), 32'(eg));
        cyc = 0;
        while (busy && cyc < 20) begin
            cyc++;
            if (cyc == drop_after) req = '0;
            if (seed_in_step && cyc == 2) begin
                seed_we = 1'b1;
                seed = 3'b111;
            end else begin
                seed_we = 1'b0;
            end
            @(negedge clk);
        end
        req = '0;
        seed_we = 1'b0;
        check("occupancy", 32'(cyc), STEPS + 1);
        check("one_valid", 32'(vcount - v0), 1);
        check("data_hold", 32'(data), 32'(ed));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int cyc, v0;
        #12;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_data", 32'(data), 0);
        check("rst_busy", 32'(busy), 0);
        #5 rst_n = 1'b1;

        // Walk 001 -> 010,101,011 -> 111,110,100 -> 001,010,101
        txn(4'b0001, 4'b0001, 3'b011, 1, 1'b0);
        txn(4'b0001, 4'b0001, 3'b100, 1, 1'b0);
        txn(4'b0001, 4'b0001, 3'b101, 1, 1'b0);

        // Held all-request after reset: round robin from requester 0
        pulse_reset();
        push(4'b0001, 3'b011);
        push(4'b0010, 3'b100);
        push(4'b0100, 3'b101);
        push(4'b1000, 3'b110);
        push(4'b0001, 3'b010);
        v0 = vcount;
        @(negedge clk);
        req = 4'b1111;
        cyc = 0;
        while (vcount < v0 + 5 && cyc < 60) begin
            cyc++;
            @(negedge clk);
        end
        req = '0;
        cyc = 0;
        while (busy && cyc < 10) begin
            cyc++;
            @(negedge clk);
        end
        check("rr_valid_count", 32'(vcount - v0), 5);

        // Zero seed promotes to 001, then seed_we during STEP is ignored
        @(negedge clk);
        seed_we = 1'b1;
        seed = 3'b000;
        @(negedge clk);
        seed_we = 1'b0;
        txn(4'b0001, 4'b0001, 3'b011, 1, 1'b0);
        txn(4'b0010, 4'b0010, 3'b100, 1, 1'b1);

        // Req dropped in second STEP still completes; last advances to 2
        txn(4'b0100, 4'b0100, 3'b101, 2, 1'b0);
        txn(4'b0101, 4'b0001, 3'b110, 1, 1'b0);

        // Seed and request together: seed wins, grant follows next cycle
        push(4'b0010, 3'b110);
        @(negedge clk);
        seed_we = 1'b1;
        seed = 3'b101;
        req = 4'b0010;
        @(negedge clk);
        check("seed_wins", 32'(busy), 0);
        seed_we = 1'b0;
        @(negedge clk);
        check("grant_after_seed", 32'(gnt), 32'(4'b0010));
        req = '0;
        cyc = 0;
        while (busy && cyc < 10) begin
            cyc++;
            @(negedge clk);
        end
        check("seed_txn_len", 32'(cyc), STEPS + 1);

        // Asynchronous reset mid-STEP aborts without a strobe
        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        check("abort_busy_before", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_gnt", 32'(gnt), 0);
        check("abort_valid", 32'(valid), 0);
        check("abort_busy", 32'(busy), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        txn(4'b0001, 4'b0001, 3'b011, 1, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
